// File: rtl/load_writeback_unit_pkg.sv
// ============================================================================
// Module   : load_writeback_unit_pkg
// Brief    : Shared load encodings, FSM state type and dmem sizing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package load_writeback_unit_pkg;

    localparam int DMEM_ADDR_W = 13;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WB   = 2'd2
    } ld_state_t;

    // True when the load must be rejected without touching memory.
    function automatic logic ld_bad(input logic [2:0] funct3, input logic [1:0] lane);
        logic bad;
        case (funct3)
            F3_LB, F3_LBU: bad = 1'b0;
            F3_LH, F3_LHU: bad = lane[0];
            F3_LW:         bad = (lane != 2'b00);
            default:       bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

`default_nettype wire

// File: rtl/load_writeback_unit_if.sv
// ============================================================================
// Module   : load_writeback_unit_if
// Brief    : Execute, dmem and regfile-write signals of the load unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface load_writeback_unit_if #(
    parameter int ADDR_W = 13
) ();
    logic              i_ld_valid;
    logic              o_ld_ready;
    logic [31:0]       i_ld_addr;
    logic [2:0]        i_ld_funct3;
    logic [4:0]        i_ld_rd;
    logic              o_stall;
    logic              o_mem_req;
    logic [ADDR_W-1:0] o_mem_addr;
    logic              i_mem_ack;
    logic [31:0]       i_mem_rdata;
    logic              o_rd_wren;
    logic [4:0]        o_rd_addr;
    logic [31:0]       o_rd_data;
    logic              o_ld_err;

    modport master (
        input  i_ld_valid, i_ld_addr, i_ld_funct3, i_ld_rd, i_mem_ack, i_mem_rdata,
        output o_ld_ready, o_stall, o_mem_req, o_mem_addr, o_rd_wren, o_rd_addr,
               o_rd_data, o_ld_err
    );

    modport slave (
        output i_ld_valid, i_ld_addr, i_ld_funct3, i_ld_rd, i_mem_ack, i_mem_rdata,
        input  o_ld_ready, o_stall, o_mem_req, o_mem_addr, o_rd_wren, o_rd_addr,
               o_rd_data, o_ld_err
    );
endinterface

`default_nettype wire

// File: rtl/load_align_ext.sv
// ============================================================================
// Module   : load_align_ext
// Brief    : Lane select and sign/zero extension of a little-endian load word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_align_ext
    import load_writeback_unit_pkg::*;
(
    input  wire logic [31:0] i_word,
    input  wire logic [1:0]  i_lane,
    input  wire logic [2:0]  i_funct3,
    output logic      [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_lane)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];

        case (i_funct3)
            F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            F3_LH:   o_data = {{16{w_half[15]}}, w_half};
            F3_LBU:  o_data = {24'd0, w_byte};
            F3_LHU:  o_data = {16'd0, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/load_writeback_unit.sv
// ============================================================================
// Module   : load_writeback_unit
// Brief    : Accepts a load, reads dmem via req/ack, writes the aligned result
//            to the regfile; flags misaligned/illegal loads and bus timeouts.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_writeback_unit
    import load_writeback_unit_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16,
    parameter int ADDR_W      = DMEM_ADDR_W
) (
    input  wire logic        i_clk,
    input  wire logic        i_rst_n,
    load_writeback_unit_if.master bus
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    ld_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [1:0]        lane_q, lane_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [4:0]        rd_q, rd_d;
    logic              rd_wren_q, rd_wren_d;
    logic [4:0]        rd_addr_q, rd_addr_d;
    logic [31:0]       rd_data_q, rd_data_d;
    logic              ld_err_q, ld_err_d;

    logic [31:0]       w_ext;
    logic              w_unused_addr_hi;

    assign w_unused_addr_hi = ^bus.i_ld_addr[31:ADDR_W];

    load_align_ext u_align (
        .i_word   (bus.i_mem_rdata),
        .i_lane   (lane_q),
        .i_funct3 (funct3_q),
        .o_data   (w_ext)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        lane_d     = lane_q;
        funct3_d   = funct3_q;
        rd_d       = rd_q;
        rd_wren_d  = 1'b0;
        rd_addr_d  = rd_addr_q;
        rd_data_d  = rd_data_q;
        ld_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.i_ld_valid) begin
                    if (ld_bad(bus.i_ld_funct3, bus.i_ld_addr[1:0])) begin
                        ld_err_d = 1'b1;
                    end else begin
                        state_d    = REQ;
                        cnt_d      = '0;
                        mem_req_d  = 1'b1;
                        mem_addr_d = {bus.i_ld_addr[ADDR_W-1:2], 2'b00};
                        lane_d     = bus.i_ld_addr[1:0];
                        funct3_d   = bus.i_ld_funct3;
                        rd_d       = bus.i_ld_rd;
                    end
                end
            end
            REQ: begin
                if (bus.i_mem_ack) begin
                    state_d   = WB;
                    mem_req_d = 1'b0;
                    // x0 is never written, and the visible rd bus keeps its last value.
                    if (rd_q != 5'd0) begin
                        rd_wren_d = 1'b1;
                        rd_addr_d = rd_q;
                        rd_data_d = w_ext;
                    end
                end else if (cnt_q == C_CNT_LAST) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    ld_err_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WB: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            lane_q     <= 2'b00;
            funct3_q   <= 3'b000;
            rd_q       <= 5'd0;
            rd_wren_q  <= 1'b0;
            rd_addr_q  <= 5'd0;
            rd_data_q  <= 32'd0;
            ld_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            lane_q     <= lane_d;
            funct3_q   <= funct3_d;
            rd_q       <= rd_d;
            rd_wren_q  <= rd_wren_d;
            rd_addr_q  <= rd_addr_d;
            rd_data_q  <= rd_data_d;
            ld_err_q   <= ld_err_d;
        end
    end

    assign bus.o_ld_ready = (state_q == IDLE);
    assign bus.o_stall    = (state_q != IDLE);
    assign bus.o_mem_req  = mem_req_q;
    assign bus.o_mem_addr = mem_addr_q;
    assign bus.o_rd_wren  = rd_wren_q;
    assign bus.o_rd_addr  = rd_addr_q;
    assign bus.o_rd_data  = rd_data_q;
    assign bus.o_ld_err   = ld_err_q;

endmodule

`default_nettype wire

// File: tb/tb_load_writeback_unit.sv
// ============================================================================
// Module   : tb_load_writeback_unit
// Brief    : Randomized self-checking bench for load_writeback_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_writeback_unit;

    localparam int TO = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    load_writeback_unit_if #(.ADDR_W(13)) bus ();

    load_writeback_unit #(.TIMEOUT_CYC(TO), .ADDR_W(13)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Architectural view of the regfile write bus: last value written.
    logic [4:0]  m_rd_addr = 5'd0;
    logic [31:0] m_rd_data = 32'd0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit ref_bad(input logic [2:0] f3, input logic [31:0] addr);
        case (f3)
            3'd0, 3'd4: return 1'b0;
            3'd1, 3'd5: return (addr % 2) != 0;
            3'd2:       return (addr % 4) != 0;
            default:    return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [31:0] addr,
                                             input logic [2:0] f3);
        logic [31:0] b, h;
        b = (word >> ((addr % 4) * 8)) & 32'hFF;
        h = (word >> (((addr / 2) % 2) * 16)) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'h80)   ? b + 32'hFFFF_FF00 : b;
            3'd1:    return (h >= 32'h8000) ? h + 32'hFFFF_0000 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return word;
        endcase
    endfunction

    // Called just after a falling edge; returns just after a falling edge.
    task automatic run_load(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] rd,
                            input logic [31:0] word, input int lat, input bit noisy);
        bit          acked = 1'b0;
        logic [31:0] exp_maddr;
        exp_maddr = addr % 32'h2000 - addr % 4;
        check_val("idle_ready", bus.o_ld_ready, 1);
        bus.i_ld_valid  = 1'b1;
        bus.i_ld_addr   = addr;
        bus.i_ld_funct3 = f3;
        bus.i_ld_rd     = rd;
        @(negedge clk);
        bus.i_ld_valid = 1'b0;
        if (ref_bad(f3, addr)) begin
            check_val("bad_err",   bus.o_ld_err, 1);
            check_val("bad_req",   bus.o_mem_req, 0);
            check_val("bad_wren",  bus.o_rd_wren, 0);
            check_val("bad_ready", bus.o_ld_ready, 1);
            @(negedge clk);
            check_val("bad_err_1pulse", bus.o_ld_err, 0);
            check_val("bad_req_after",  bus.o_mem_req, 0);
            return;
        end
        for (int k = 0; k < TO; k++) begin
            check_val("req_req",   bus.o_mem_req, 1);
            check_val("req_stall", bus.o_stall, 1);
            check_val("req_ready", bus.o_ld_ready, 0);
            check_val("req_maddr", 32'(bus.o_mem_addr), exp_maddr);
            check_val("req_wren",  bus.o_rd_wren, 0);
            check_val("req_err",   bus.o_ld_err, 0);
            bus.i_mem_ack   = (k == lat);
            bus.i_mem_rdata = (k == lat) ? word : $urandom;
            if (noisy) begin
                bus.i_ld_valid  = 1'($urandom_range(0, 1));
                bus.i_ld_addr   = $urandom;
                bus.i_ld_funct3 = 3'($urandom);
                bus.i_ld_rd     = 5'($urandom);
            end
            @(negedge clk);
            bus.i_mem_ack  = 1'b0;
            bus.i_ld_valid = 1'b0;
            if (k == lat) begin
                acked = 1'b1;
                break;
            end
        end
        if (acked) begin
            if (rd != 5'd0) begin
                m_rd_addr = rd;
                m_rd_data = ref_load(word, addr, f3);
            end
            check_val("wb_wren",    bus.o_rd_wren, (rd != 5'd0));
            check_val("wb_stall",   bus.o_stall, 1);
            check_val("wb_rd_addr", bus.o_rd_addr, m_rd_addr);
            check_val("wb_rd_data", bus.o_rd_data, m_rd_data);
            check_val("wb_err",     bus.o_ld_err, 0);
            @(negedge clk);
            check_val("post_wren",  bus.o_rd_wren, 0);
            check_val("post_ready", bus.o_ld_ready, 1);
            check_val("post_stall", bus.o_stall, 0);
            check_val("post_req",   bus.o_mem_req, 0);
            check_val("post_data",  bus.o_rd_data, m_rd_data);
        end else begin
            check_val("to_req",   bus.o_mem_req, 0);
            check_val("to_err",   bus.o_ld_err, 1);
            check_val("to_ready", bus.o_ld_ready, 1);
            check_val("to_wren",  bus.o_rd_wren, 0);
            bus.i_mem_ack   = 1'b1;
            bus.i_mem_rdata = $urandom;
            @(negedge clk);
            bus.i_mem_ack = 1'b0;
            check_val("late_ack_wren", bus.o_rd_wren, 0);
            check_val("late_ack_err",  bus.o_ld_err, 0);
            check_val("late_ack_req",  bus.o_mem_req, 0);
            check_val("late_ack_data", bus.o_rd_data, m_rd_data);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] addr;
        logic [2:0]  f3;
        int          r, lat;

        bus.i_ld_valid  = 1'b0;
        bus.i_ld_addr   = '0;
        bus.i_ld_funct3 = '0;
        bus.i_ld_rd     = '0;
        bus.i_mem_ack   = 1'b0;
        bus.i_mem_rdata = '0;

        repeat (3) @(negedge clk);
        check_val("rst_ready",   bus.o_ld_ready, 1);
        check_val("rst_stall",   bus.o_stall, 0);
        check_val("rst_req",     bus.o_mem_req, 0);
        check_val("rst_maddr",   32'(bus.o_mem_addr), 0);
        check_val("rst_wren",    bus.o_rd_wren, 0);
        check_val("rst_rd_addr", bus.o_rd_addr, 0);
        check_val("rst_rd_data", bus.o_rd_data, 0);
        check_val("rst_err",     bus.o_ld_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_load(32'h0000_0003, 3'b000, 5'd5, 32'h80FF_1234, 0, 1'b0);
        check_val("lb_value", bus.o_rd_data, 32'hFFFF_FF80);
        run_load(32'h0000_0002, 3'b101, 5'd7, 32'h8001_7FFF, 3, 1'b0);
        check_val("lhu_value", bus.o_rd_data, 32'h0000_8001);
        run_load(32'h0000_1FFC, 3'b010, 5'd0, 32'hDEAD_BEEF, 1, 1'b0);
        run_load(32'h0000_0001, 3'b001, 5'd3, 32'h1111_1111, 0, 1'b0);
        run_load(32'h0000_0000, 3'b011, 5'd3, 32'h1111_1111, 0, 1'b0);
        run_load(32'h0000_0040, 3'b010, 5'd4, 32'h2222_2222, TO, 1'b0);

        // Asynchronous reset in the middle of a request.
        check_val("arst_ready0", bus.o_ld_ready, 1);
        bus.i_ld_valid  = 1'b1;
        bus.i_ld_addr   = 32'h0000_0010;
        bus.i_ld_funct3 = 3'b010;
        bus.i_ld_rd     = 5'd9;
        @(negedge clk);
        bus.i_ld_valid = 1'b0;
        @(negedge clk);
        check_val("arst_req_before", bus.o_mem_req, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_req",   bus.o_mem_req, 0);
        check_val("arst_stall", bus.o_stall, 0);
        check_val("arst_ready", bus.o_ld_ready, 1);
        m_rd_addr = 5'd0;
        m_rd_data = 32'd0;
        check_val("arst_data",  bus.o_rd_data, m_rd_data);
        bus.i_mem_ack = 1'b1;
        @(negedge clk);
        bus.i_mem_ack = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check_val("arst_wren_after", bus.o_rd_wren, 0);
        check_val("arst_req_after",  bus.o_mem_req, 0);
        run_load(32'h0000_0010, 3'b010, 5'd9, 32'hCAFE_F00D, 2, 1'b0);

        for (int i = 0; i < 300; i++) begin
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 4))
                    0:       f3 = 3'b000;
                    1:       f3 = 3'b001;
                    2:       f3 = 3'b010;
                    3:       f3 = 3'b100;
                    default: f3 = 3'b101;
                endcase
                if ($urandom_range(0, 3) != 0) addr = addr - addr % 4 + ((f3 == 3'b010) ? 0 : (addr % 2) * 2);
            end else begin
                f3 = 3'($urandom);
            end
            r = $urandom_range(0, 9);
            if (r < 8)       lat = r % 4;
            else if (r == 8) lat = TO;
            else             lat = $urandom_range(4, TO - 1);
            run_load(addr, f3, 5'($urandom), $urandom, lat, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) begin
                bus.i_mem_ack   = 1'($urandom_range(0, 1));
                bus.i_mem_rdata = $urandom;
                @(negedge clk);
                bus.i_mem_ack = 1'b0;
                check_val("idle_ack_ignored", bus.o_mem_req, 0);
                check_val("idle_ack_wren",    bus.o_rd_wren, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
